// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU with a status register. Most operations finish
//                in one cycle. Shifts move one bit per cycle and the multiply
//                does one shift-add step per cycle; both hold busy while active.
//                Branch opcodes resolve against the status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             branch,
    output logic             zflag,
    output logic             nflag,
    output logic             cflag,
    output logic             vflag,
    output logic             hflag,
    output logic             sflag
);

    localparam int HALF = WIDTH / 2;
    // Counter wide enough to hold WIDTH itself (max shift distance / MUL steps)
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [4:0] c_op_ld  = 5'h01;
    localparam logic [4:0] c_op_st  = 5'h02;
    localparam logic [4:0] c_op_add = 5'h03;
    localparam logic [4:0] c_op_sub = 5'h04;
    localparam logic [4:0] c_op_and = 5'h05;
    localparam logic [4:0] c_op_or  = 5'h06;
    localparam logic [4:0] c_op_xor = 5'h07;
    localparam logic [4:0] c_op_not = 5'h08;
    localparam logic [4:0] c_op_sl  = 5'h09;
    localparam logic [4:0] c_op_sr  = 5'h0A;
    localparam logic [4:0] c_op_mul = 5'h0B;
    localparam logic [4:0] c_op_bz  = 5'h10;
    localparam logic [4:0] c_op_bnz = 5'h11;
    localparam logic [4:0] c_op_bra = 5'h12;

    localparam logic [WIDTH-1:0] c_width_w = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    c_k_max   = CW'(WIDTH);

    typedef enum logic [0:0] {
        c_st_idle = 1'b0,
        c_st_exec = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_done;
    logic                 r_branch;
    logic [WIDTH-1:0]     r_out;
    logic                 r_z, r_n, r_c, r_v, r_h;

    // Multi-cycle context captured at accept so later input changes are ignored
    logic                 r_is_mul;
    logic                 r_dir_right;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_sh;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    // Single-cycle arithmetic helpers
    logic [WIDTH:0]       w_sum;
    logic [HALF:0]        w_hsum;
    logic [WIDTH-1:0]     w_diff;
    logic [CW-1:0]        w_k;
    logic                 w_is_mul;
    logic                 w_is_shift;

    // Iterative datapath next values
    logic [WIDTH-1:0]     w_sh_next;
    logic                 w_sh_bit;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Single-cycle result bundle
    logic [WIDTH-1:0]     w_res_out;
    logic                 w_res_z, w_res_n, w_res_c, w_res_v, w_res_h;
    logic                 w_upd_out;
    logic                 w_upd_flags;
    logic                 w_res_branch;

    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_hsum     = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]};
    assign w_diff     = a - b;
    // Shift distance saturates at WIDTH; anything beyond that clears the word
    assign w_k        = (b > c_width_w) ? c_k_max : b[CW-1:0];
    assign w_is_mul   = (op == c_op_mul);
    assign w_is_shift = (op == c_op_sl) || (op == c_op_sr);

    assign w_sh_next  = r_dir_right ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
    assign w_sh_bit   = r_dir_right ? r_sh[0] : r_sh[WIDTH-1];
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign busy   = (r_state == c_st_exec);
    assign done   = r_done;
    assign out    = r_out;
    assign branch = r_branch;
    assign zflag  = r_z;
    assign nflag  = r_n;
    assign cflag  = r_c;
    assign vflag  = r_v;
    assign hflag  = r_h;
    assign sflag  = r_n ^ r_v;

    // Decode the operation into the result it would commit if finished this cycle
    always_comb begin
        w_res_out    = r_out;
        w_res_c      = 1'b0;
        w_res_v      = 1'b0;
        w_res_h      = 1'b0;
        w_upd_out    = 1'b0;
        w_upd_flags  = 1'b0;
        w_res_branch = 1'b0;
        case (op)
            c_op_ld: begin
                w_res_out = b;
                w_upd_out = 1'b1;
            end
            c_op_st: begin
                w_res_out = a;
                w_upd_out = 1'b1;
            end
            c_op_add: begin
                w_res_out   = w_sum[WIDTH-1:0];
                w_res_c     = w_sum[WIDTH];
                w_res_h     = w_hsum[HALF];
                w_res_v     = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_sub: begin
                w_res_out   = w_diff;
                w_res_c     = (a < b);
                w_res_h     = (a[HALF-1:0] < b[HALF-1:0]);
                w_res_v     = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_and: begin
                w_res_out   = a & b;
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_or: begin
                w_res_out   = a | b;
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_xor: begin
                w_res_out   = a ^ b;
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_not: begin
                w_res_out   = ~a;
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_sl, c_op_sr: begin
                // Only the zero-distance shift completes here; others go to EXEC
                w_res_out   = a;
                w_upd_out   = 1'b1;
                w_upd_flags = 1'b1;
            end
            c_op_bz: begin
                if (r_z) begin
                    w_res_out    = b;
                    w_upd_out    = 1'b1;
                    w_res_branch = 1'b1;
                end
            end
            c_op_bnz: begin
                if (!r_z) begin
                    w_res_out    = b;
                    w_upd_out    = 1'b1;
                    w_res_branch = 1'b1;
                end
            end
            c_op_bra: begin
                w_res_out    = b;
                w_upd_out    = 1'b1;
                w_res_branch = 1'b1;
            end
            default: begin
            end
        endcase
        w_res_z = (w_res_out == '0);
        w_res_n = w_res_out[WIDTH-1];
    end

    // Control FSM plus all architectural and iterative state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_done      <= 1'b0;
            r_branch    <= 1'b0;
            r_out       <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_h         <= 1'b0;
            r_is_mul    <= 1'b0;
            r_dir_right <= 1'b0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (w_is_mul) begin
                            r_state  <= c_st_exec;
                            r_is_mul <= 1'b1;
                            r_cnt    <= c_k_max;
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                        end else if (w_is_shift && (w_k != '0)) begin
                            r_state     <= c_st_exec;
                            r_is_mul    <= 1'b0;
                            r_dir_right <= (op == c_op_sr);
                            r_cnt       <= w_k;
                            r_sh        <= a;
                        end else begin
                            r_done   <= 1'b1;
                            r_branch <= w_res_branch;
                            if (w_upd_out) begin
                                r_out <= w_res_out;
                            end
                            if (w_upd_flags) begin
                                r_z <= w_res_z;
                                r_n <= w_res_n;
                                r_c <= w_res_c;
                                r_v <= w_res_v;
                                r_h <= w_res_h;
                            end
                        end
                    end
                end
                c_st_exec: begin
                    r_cnt    <= r_cnt - CW'(1);
                    r_sh     <= w_sh_next;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CW'(1)) begin
                        r_state  <= c_st_idle;
                        r_done   <= 1'b1;
                        r_branch <= 1'b0;
                        r_h      <= 1'b0;
                        if (r_is_mul) begin
                            r_out <= w_acc_next[WIDTH-1:0];
                            r_z   <= (w_acc_next[WIDTH-1:0] == '0);
                            r_n   <= w_acc_next[WIDTH-1];
                            r_c   <= |w_acc_next[2*WIDTH-1:WIDTH];
                            r_v   <= |w_acc_next[2*WIDTH-1:WIDTH];
                        end else begin
                            r_out <= w_sh_next;
                            r_z   <= (w_sh_next == '0);
                            r_n   <= w_sh_next[WIDTH-1];
                            r_c   <= w_sh_bit;
                            r_v   <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu (WIDTH=32). A transaction-level
//                model predicts out/flags/busy/done each cycle; directed vectors
//                carry hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam logic [4:0] OP_LD  = 5'h01;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_AND = 5'h05;
    localparam logic [4:0] OP_OR  = 5'h06;
    localparam logic [4:0] OP_XOR = 5'h07;
    localparam logic [4:0] OP_NOT = 5'h08;
    localparam logic [4:0] OP_SL  = 5'h09;
    localparam logic [4:0] OP_SR  = 5'h0A;
    localparam logic [4:0] OP_MUL = 5'h0B;
    localparam logic [4:0] OP_BZ  = 5'h10;
    localparam logic [4:0] OP_BNZ = 5'h11;
    localparam logic [4:0] OP_BRA = 5'h12;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy, done, branch;
    logic [31:0] out;
    logic        zflag, nflag, cflag, vflag, hflag, sflag;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .branch(branch),
        .zflag(zflag), .nflag(nflag), .cflag(cflag), .vflag(vflag),
        .hflag(hflag), .sflag(sflag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_rem = 0;
    logic [31:0] m_out;
    logic        m_z, m_n, m_c, m_v, m_h, m_done, m_branch;
    logic [31:0] p_out;
    logic        p_c, p_v, p_h, p_upd_out, p_upd_flags;
    logic [63:0] t_full;
    longint      t_s;
    int          t_k;

    task automatic apply_pending();
        if (p_upd_out) m_out = p_out;
        if (p_upd_flags) begin
            m_z = (p_out == 32'h0);
            m_n = p_out[31];
            m_c = p_c;
            m_v = p_v;
            m_h = p_h;
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_rem = 0; m_out = '0; m_branch = 1'b0;
            m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_h = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                apply_pending();
                m_done = 1'b1;
                m_branch = 1'b0;
            end
        end else if (start) begin
            p_out = m_out; p_c = 0; p_v = 0; p_h = 0;
            p_upd_out = 1'b1; p_upd_flags = 1'b1;
            m_branch = 1'b0;
            t_k = 0;
            case (op)
                5'h01: begin p_out = b; p_upd_flags = 0; end
                5'h02: begin p_out = a; p_upd_flags = 0; end
                5'h03: begin
                    t_full = {32'h0, a} + {32'h0, b};
                    t_s = longint'($signed(a)) + longint'($signed(b));
                    p_out = t_full[31:0]; p_c = t_full[32];
                    p_h = (int'(a[15:0]) + int'(b[15:0])) > 65535;
                    p_v = (t_s > SMAX) || (t_s < SMIN);
                end
                5'h04: begin
                    t_s = longint'($signed(a)) - longint'($signed(b));
                    p_out = a - b; p_c = (a < b); p_h = (a[15:0] < b[15:0]);
                    p_v = (t_s > SMAX) || (t_s < SMIN);
                end
                5'h05: p_out = a & b;
                5'h06: p_out = a | b;
                5'h07: p_out = a ^ b;
                5'h08: p_out = ~a;
                5'h09: begin
                    t_k = (b > 32'd32) ? 32 : int'(b);
                    t_full = {32'h0, a} << t_k;
                    p_out = t_full[31:0]; p_c = t_full[32];
                end
                5'h0A: begin
                    t_k = (b > 32'd32) ? 32 : int'(b);
                    t_full = {a, 32'h0} >> t_k;
                    p_out = t_full[63:32]; p_c = t_full[31];
                end
                5'h0B: begin
                    t_full = {32'h0, a} * {32'h0, b};
                    p_out = t_full[31:0];
                    p_c = (t_full[63:32] != 0); p_v = p_c;
                    t_k = 32;
                end
                5'h10, 5'h11, 5'h12: begin
                    p_upd_flags = 0;
                    if ((op == 5'h12) || ((op == 5'h10) == m_z)) begin
                        p_out = b; m_branch = 1'b1;
                    end else begin
                        p_upd_out = 0;
                    end
                end
                default: begin p_upd_out = 0; p_upd_flags = 0; end
            endcase
            if (t_k == 0) begin
                apply_pending();
                m_done = 1'b1;
            end else begin
                m_rem = t_k;
            end
        end
    end

    // Per-cycle comparison of DUT against the model
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("busy",  busy,  m_rem > 0);
            chk("done",  done,  m_done);
            chk("out",   out,   m_out);
            chk("zflag", zflag, m_z);
            chk("nflag", nflag, m_n);
            chk("cflag", cflag, m_c);
            chk("vflag", vflag, m_v);
            chk("hflag", hflag, m_h);
            chk("sflag", sflag, m_n ^ m_v);
            if (m_done) chk("branch", branch, m_branch);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int lat = 1;
        while (done !== 1'b1 && lat < exp_lat + 5) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_out", out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {zflag, nflag, cflag, vflag, hflag}, 5'b0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        wait_done(1, "add");
        chk("add_out", out, 32'h0);
        chk("add_znchv", {zflag, nflag, cflag, hflag, vflag}, 5'b10110);
        chk("add_busy", busy, 1'b0);

        issue(OP_BZ, 32'h0, 32'h40);
        wait_done(1, "bz");
        chk("bz_branch", branch, 1'b1);
        chk("bz_out", out, 32'h40);
        chk("bz_flags", {zflag, nflag, cflag, hflag, vflag}, 5'b10110);

        issue(OP_BNZ, 32'h0, 32'h80);
        wait_done(1, "bnz");
        chk("bnz_branch", branch, 1'b0);
        chk("bnz_out", out, 32'h40);

        issue(OP_SUB, 32'h8000_0000, 32'h1);
        wait_done(1, "sub");
        chk("sub_out", out, 32'h7FFF_FFFF);
        chk("sub_vnc", {vflag, nflag, cflag}, 3'b100);
        chk("sub_sflag", sflag, 1'b1);

        issue(OP_SL, 32'h8000_0001, 32'h1);
        chk("sl_busy", busy, 1'b1);
        chk("sl_done_early", done, 1'b0);
        wait_done(2, "sl");
        chk("sl_out", out, 32'h2);
        chk("sl_c", cflag, 1'b1);
        issue(OP_SR, 32'hF0F0_000F, 32'h4);
        chk("b2b_accept_busy", busy, 1'b1);
        wait_done(5, "sr4");
        chk("sr4_out", out, 32'h0F0F_0000);
        chk("sr4_c", cflag, 1'b1);

        issue(OP_SL, 32'h1234_5678, 32'h0);
        wait_done(1, "sl0");
        chk("sl0_out", out, 32'h1234_5678);
        chk("sl0_c", cflag, 1'b0);

        issue(OP_SR, 32'h8000_0000, 32'd100);
        wait_done(33, "sr_sat");
        chk("sr_sat_out", out, 32'h0);
        chk("sr_sat_zc", {zflag, cflag}, 2'b11);

        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(1, "and");
        chk("and_out", out, 32'hF000_F000);
        issue(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(1, "or");
        chk("or_out", out, 32'hFFF0_FFF0);
        issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(1, "xor");
        chk("xor_out", out, 32'h0FF0_0FF0);
        issue(OP_NOT, 32'h0, 32'h0);
        wait_done(1, "not");
        chk("not_out", out, 32'hFFFF_FFFF);
        chk("not_nc", {nflag, cflag}, 2'b10);

        // MUL with start pulses and operand changes while busy
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            start = lat[0]; op = OP_ADD; a = $urandom; b = $urandom;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("mul_latency", lat, 33);
        chk("mul_out", out, 32'h0);
        chk("mul_zcv", {zflag, cflag, vflag}, 3'b111);

        issue(OP_MUL, 32'h1234, 32'h5678);
        wait_done(33, "mul2");
        chk("mul2_out", out, 32'h0626_0060);
        chk("mul2_cv", {cflag, vflag}, 2'b00);

        issue(5'h0C, 32'h1, 32'h2);
        wait_done(1, "undef");
        chk("undef_out", out, 32'h0626_0060);
        chk("undef_branch", branch, 1'b0);

        issue(OP_BRA, 32'h0, 32'h100);
        wait_done(1, "bra");
        chk("bra_out", out, 32'h100);
        chk("bra_branch", branch, 1'b1);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_done(1, "addov");
        chk("addov_out", out, 32'h8000_0000);
        chk("addov_nvch", {nflag, vflag, cflag, hflag}, 4'b1101);
        chk("addov_sflag", sflag, 1'b0);

        issue(OP_LD, 32'h0, 32'hABCD);
        wait_done(1, "ld");
        chk("ld_out", out, 32'hABCD);
        chk("ld_flags_kept", {nflag, vflag}, 2'b11);

        // Reset during a MUL aborts it with no done
        issue(OP_MUL, 32'h3, 32'h5);
        repeat (9) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out", out, 32'h0);
        chk("abort_flags", {zflag, nflag, cflag, vflag, hflag}, 5'b0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
